rectify_pair_seq: RTL and testbench

//  Sequential, handshaked successor to the combinational collision position rectifier. Takes one

---
 rtl/rectify_pair_seq.sv | 178 +++++++++++++++++
 tb/tb_rectify_pair_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rectify_pair_seq.sv
// Handshaked ball-pair overlap rectifier. It pushes an overlapping pair apart along the
// collision normal using a bit-serial sqrt and a shared restoring divider. One pair is in flight at a time.
module rectify_pair_seq #(
  parameter int WIDTH      = 32,
  parameter int FRAC_WIDTH = 30,
  parameter int EPS        = 10,
  parameter int SPLIT_MODE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] x0,
  input  logic signed [WIDTH-1:0] y0,
  input  logic signed [WIDTH-1:0] x1,
  input  logic signed [WIDTH-1:0] y1,
  input  logic signed [WIDTH-1:0] r0,
  input  logic signed [WIDTH-1:0] r1,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    hit,
  output logic signed [WIDTH-1:0] new_x0,
  output logic signed [WIDTH-1:0] new_y0,
  output logic signed [WIDTH-1:0] new_x1,
  output logic signed [WIDTH-1:0] new_y1
);
  localparam int W    = WIDTH;
  localparam int F    = FRAC_WIDTH;
  localparam int DW   = 2 * W;
  localparam int QW   = F + 2;
  localparam int CMAX = (W > QW) ? W : QW;
  localparam int CW   = $clog2(CMAX);
  localparam logic [CW-1:0] SQ_LAST = CW'(W - 1);
  localparam logic [CW-1:0] DV_LAST = CW'(QW - 1);
  localparam logic signed [W-1:0] ONE  = W'(64'd1 << F);
  localparam logic signed [W-1:0] EPSV = W'(64'd1 << EPS);

  typedef enum logic [2:0] {IDLE, DIFF, CMP, SQRT, DIVX, DIVY, MUL, DONE} state_t;
  typedef struct packed {
    logic signed [W-1:0] x0, y0, x1, y1, r0, r1;
  } pair_t;

  state_t state, state_nx;
  pair_t  pr;
  logic   armed, zero;
  logic signed [W-1:0] dx, dy, nx, ny;
  logic [W-1:0]  len, sq_root, sq_rem, dv_rem;
  logic [DW-1:0] sq_sh;
  logic [QW-1:0] dv_sh, dv_q;
  logic [CW-1:0] cnt;

  logic signed [W-1:0]  rsum, diff, dsc, nxf, nyf, offx, offy, n_nx;
  logic signed [DW-1:0] sdx, sdy, prx, pry;
  logic [DW-1:0] rsq, d2;
  logic [W+1:0]  sq_try, sq_trial;
  logic [W-1:0]  root_nx, adx, ady;
  logic [W:0]    dv_try;
  logic [QW-1:0] q_nx;
  logic hit_c, cnt_last, sq_ge, dv_ge, sgn;

  function automatic logic [W-1:0] mag(input logic signed [W-1:0] v);
    return v[W-1] ? W'(-v) : W'(v);
  endfunction

  assign in_ready  = armed && (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    rsum     = pr.r0 + pr.r1;
    rsq      = {{W{1'b0}}, rsum} * {{W{1'b0}}, rsum};
    sdx      = {{W{dx[W-1]}}, dx};
    sdy      = {{W{dy[W-1]}}, dy};
    d2       = sdx * sdx + sdy * sdy;
    hit_c    = d2 < rsq;
    adx      = mag(dx);
    ady      = mag(dy);
    // restoring sqrt: two radicand bits per cycle
    sq_try   = {sq_rem, sq_sh[DW-1 -: 2]};
    sq_trial = {sq_root, 2'b01};
    sq_ge    = sq_try >= sq_trial;
    root_nx  = {sq_root[W-2:0], sq_ge};
    // divider only walks the low QW quotient bits; higher ones are zero since |d| <= length
    dv_try   = {dv_rem, dv_sh[QW-1]};
    dv_ge    = dv_try >= {1'b0, len};
    q_nx     = QW'({dv_q, dv_ge});
    sgn      = (state == DIVX) ? dx[W-1] : dy[W-1];
    n_nx     = sgn ? -$signed(W'(q_nx)) : $signed(W'(q_nx));
    cnt_last = cnt == ((state == SQRT) ? SQ_LAST : DV_LAST);
    nxf      = zero ? ONE : nx;
    nyf      = zero ? '0 : ny;
    diff     = rsum - $signed(len) + EPSV;
    dsc      = (SPLIT_MODE == 0) ? (diff >>> 1) : diff;
    prx      = {{W{dsc[W-1]}}, dsc} * {{W{nxf[W-1]}}, nxf};
    pry      = {{W{dsc[W-1]}}, dsc} * {{W{nyf[W-1]}}, nyf};
    offx     = W'(prx >>> F);
    offy     = W'(pry >>> F);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:        if (in_valid && in_ready) state_nx = DIFF;
      DIFF:        state_nx = CMP;
      CMP:         state_nx = hit_c ? SQRT : DONE;
      SQRT:        if (cnt_last) state_nx = DIVX;
      DIVX:        if (cnt_last) state_nx = DIVY;
      DIVY:        if (cnt_last) state_nx = MUL;
      MUL:         state_nx = DONE;
      DONE:        if (out_ready) state_nx = IDLE;
      default:     state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed <= 1'b0; zero <= 1'b0; pr <= '0;
      dx <= '0; dy <= '0; nx <= '0; ny <= '0;
      len <= '0; sq_root <= '0; sq_rem <= '0; sq_sh <= '0;
      dv_rem <= '0; dv_sh <= '0; dv_q <= '0; cnt <= '0;
      hit <= 1'b0; new_x0 <= '0; new_y0 <= '0; new_x1 <= '0; new_y1 <= '0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: if (in_valid && in_ready) pr <= {x0, y0, x1, y1, r0, r1};
        DIFF: begin
          dx <= pr.x0 - pr.x1;
          dy <= pr.y0 - pr.y1;
        end
        CMP: begin
          sq_sh <= d2; sq_rem <= '0; sq_root <= '0; cnt <= '0;
          zero  <= (d2 == '0);
          if (!hit_c) begin
            hit <= 1'b0;
            new_x0 <= pr.x0; new_y0 <= pr.y0; new_x1 <= pr.x1; new_y1 <= pr.y1;
          end
        end
        SQRT: begin
          sq_sh   <= sq_sh << 2;
          sq_rem  <= W'(sq_ge ? sq_try - sq_trial : sq_try);
          sq_root <= root_nx;
          cnt     <= cnt_last ? '0 : cnt + 1'b1;
          if (cnt_last) begin
            len    <= root_nx;
            dv_rem <= adx >> 2;
            dv_sh  <= {adx[1:0], {F{1'b0}}};
            dv_q   <= '0;
          end
        end
        DIVX, DIVY: begin
          dv_rem <= W'(dv_ge ? dv_try - {1'b0, len} : dv_try);
          dv_sh  <= dv_sh << 1;
          dv_q   <= q_nx;
          cnt    <= cnt_last ? '0 : cnt + 1'b1;
          if (cnt_last && state == DIVX) begin
            nx     <= n_nx;
            dv_rem <= ady >> 2;
            dv_sh  <= {ady[1:0], {F{1'b0}}};
            dv_q   <= '0;
          end
          if (cnt_last && state == DIVY) ny <= n_nx;
        end
        MUL: begin
          hit    <= 1'b1;
          new_x0 <= (SPLIT_MODE == 0) ? pr.x0 + offx : pr.x0;
          new_y0 <= (SPLIT_MODE == 0) ? pr.y0 + offy : pr.y0;
          new_x1 <= pr.x1 - offx;
          new_y1 <= pr.y1 - offy;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rectify_pair_seq.sv
// Bench for rectify_pair_seq: directed cases plus randomized pairs against an arithmetic model.
module tb_rectify_pair_seq;
  localparam int W = 32, F = 16;
  localparam int LAT_HIT = W + 2 * F + 7, LAT_MISS = 2;

  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic signed [W-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0, r0 = '0, r1 = '0;
  logic in_ready, out_valid, hit, in_ready_b, out_valid_b, hit_b;
  logic signed [W-1:0] nx0, ny0, nx1, ny1, bx0, by0, bx1, by1;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  rectify_pair_seq #(.WIDTH(W), .FRAC_WIDTH(F), .EPS(10), .SPLIT_MODE(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .r0(r0), .r1(r1),
    .out_valid(out_valid), .out_ready(out_ready), .hit(hit),
    .new_x0(nx0), .new_y0(ny0), .new_x1(nx1), .new_y1(ny1));

  rectify_pair_seq #(.WIDTH(W), .FRAC_WIDTH(F), .EPS(10), .SPLIT_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .r0(r0), .r1(r1),
    .out_valid(out_valid_b), .out_ready(out_ready), .hit(hit_b),
    .new_x0(bx0), .new_y0(by0), .new_x1(bx1), .new_y1(by1));

  // Reference: exact integer sqrt, truncating division, floor shifts.
  function automatic void model(input longint ax0, ay0, ax1, ay1, ar0, ar1, input int mode,
                                output bit eh, output longint ex0, ey0, ex1, ey1);
    longint dx, dy, d2, rs, l, nx, ny, diff, d, ox, oy;
    dx = ax0 - ax1; dy = ay0 - ay1; d2 = dx * dx + dy * dy; rs = ar0 + ar1;
    eh = d2 < rs * rs;
    ex0 = ax0; ey0 = ay0; ex1 = ax1; ey1 = ay1;
    if (!eh) return;
    l = longint'($sqrt(real'(d2)));
    while (l * l > d2) l--;
    while ((l + 1) * (l + 1) <= d2) l++;
    if (d2 == 0) begin nx = 64'sd1 << F; ny = 0; end
    else begin
      nx = ((dx < 0 ? -dx : dx) << F) / l; if (dx < 0) nx = -nx;
      ny = ((dy < 0 ? -dy : dy) << F) / l; if (dy < 0) ny = -ny;
    end
    diff = rs - l + 1024;
    d = (mode == 0) ? (diff >>> 1) : diff;
    ox = (d * nx) >>> F; oy = (d * ny) >>> F;
    if (mode == 0) begin ex0 = ax0 + ox; ey0 = ay0 + oy; end
    ex1 = ax1 - ox; ey1 = ay1 - oy;
  endfunction

  task automatic start_pair(input longint a0, b0, a1, b1, c0, c1, output int waited);
    @(negedge clk);
    x0 = W'(a0); y0 = W'(b0); x1 = W'(a1); y1 = W'(b1); r0 = W'(c0); r1 = W'(c1);
    in_valid = 1'b1; waited = 0;
    while (!in_ready && waited < 50) begin @(negedge clk); waited++; end
    if (!in_ready) begin
      errors++; checks++;
      $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, want 1", in_ready, waited);
    end
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    @(negedge clk); lat = 0;
    while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
  endtask

  task automatic xfer;
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  task automatic test_reset;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %0b want 0", in_ready); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL rst_hit: got %0b want 0", hit); end
    checks++; if ({nx0, ny0, nx1, ny1} !== '0) begin errors++; $display("FAIL rst_new: got %0d %0d %0d %0d want 0", nx0, ny0, nx1, ny1); end
    rst = 1'b1; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rel_in_ready_early: got %0b want 0", in_ready); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_nohit;
    int w, lat;
    start_pair(0, 0, 196608, 0, 65536, 65536, w);
    wait_done(lat);
    checks++; if (lat != LAT_MISS) begin errors++; $display("FAIL nohit_latency: got %0d want %0d", lat, LAT_MISS); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL nohit_hit: got %0b want 0", hit); end
    checks++; if (nx0 !== 0 || nx1 !== 196608 || ny0 !== 0 || ny1 !== 0)
      begin errors++; $display("FAIL nohit_pos: got %0d %0d %0d %0d want 0 0 196608 0", nx0, ny0, nx1, ny1); end
    xfer();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL nohit_after: out_valid=%0b in_ready=%0b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_hit_axis(input string tag);
    int w, lat;
    start_pair(0, 0, 98304, 0, 65536, 65536, w);
    wait_done(lat);
    checks++; if (lat != LAT_HIT) begin errors++; $display("FAIL %s_latency: got %0d want %0d", tag, lat, LAT_HIT); end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL %s_hit: got %0b want 1", tag, hit); end
    checks++; if (nx0 !== -16896 || nx1 !== 115200 || ny0 !== 0 || ny1 !== 0)
      begin errors++; $display("FAIL %s_m0: got %0d %0d %0d %0d want -16896 0 115200 0", tag, nx0, ny0, nx1, ny1); end
    checks++; if (bx0 !== 0 || bx1 !== 132096 || hit_b !== 1'b1)
      begin errors++; $display("FAIL %s_m1: got %0d %0d hit=%0b want 0 132096 1", tag, bx0, bx1, hit_b); end
    xfer();
  endtask

  task automatic test_diag;
    int w, lat, dx0, dy0, dx1, dy1;
    start_pair(0, 0, 98304, 131072, 131072, 131072, w);
    wait_done(lat);
    dx0 = nx0 + 29799; dy0 = ny0 + 39731; dx1 = nx1 - 128103; dy1 = ny1 - 170803;
    checks++; if (dx0 > 1 || dx0 < -1 || dy0 > 1 || dy0 < -1 || dx1 > 1 || dx1 < -1 || dy1 > 1 || dy1 < -1)
      begin errors++; $display("FAIL diag_pos: got %0d %0d %0d %0d want -29799 -39731 128103 170803", nx0, ny0, nx1, ny1); end
    xfer();
  endtask

  task automatic test_coincident;
    int w, lat;
    start_pair(65536, 65536, 65536, 65536, 32768, 32768, w);
    wait_done(lat);
    checks++; if (lat != LAT_HIT) begin errors++; $display("FAIL coinc_latency: got %0d want %0d", lat, LAT_HIT); end
    checks++; if (nx0 !== 98816 || nx1 !== 32256 || ny0 !== 65536 || ny1 !== 65536)
      begin errors++; $display("FAIL coinc_pos: got %0d %0d %0d %0d want 98816 65536 32256 65536", nx0, ny0, nx1, ny1); end
    xfer();
  endtask

  task automatic test_backpressure;
    int w, lat, bad;
    start_pair(0, 0, 98304, 0, 65536, 65536, w);
    wait_done(lat);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      x0 = W'(i * 1000); x1 = 7;
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || nx0 !== -16896 || nx1 !== 115200) bad++;
    end
    in_valid = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold: %0d bad cycles want 0", bad); end
    xfer();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_single_xfer: %0d bad cycles want 0", bad); end
  endtask

  task automatic test_reset_midop;
    int w;
    start_pair(0, 0, 98304, 0, 65536, 65536, w);
    repeat (10) @(negedge clk);
    rst = 1'b0; #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || hit !== 1'b0 || nx1 !== 0)
      begin errors++; $display("FAIL midop_abort: out_valid=%0b in_ready=%0b hit=%0b nx1=%0d want 0", out_valid, in_ready, hit, nx1); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    test_hit_axis("rerun");
  endtask

  task automatic test_back_to_back;
    int w, lat;
    start_pair(0, 0, 196608, 0, 65536, 65536, w);
    wait_done(lat);
    xfer();
    start_pair(0, 0, 98304, 0, 65536, 65536, w);
    checks++; if (w != 0) begin errors++; $display("FAIL b2b_wait: got %0d want 0", w); end
    wait_done(lat);
    checks++; if (lat != LAT_HIT || nx1 !== 115200)
      begin errors++; $display("FAIL b2b_second: lat=%0d nx1=%0d want %0d 115200", lat, nx1, LAT_HIT); end
    xfer();
  endtask

  task automatic test_random;
    int w, lat, nhit;
    longint a0, b0, a1, b1, c0, c1, e0, f0, e1, f1, g0, h0, g1, h1;
    bit eh, eh1;
    nhit = 0;
    for (int i = 0; i < 30; i++) begin
      a0 = longint'($urandom_range(0, 2097152)) - 1048576;
      b0 = longint'($urandom_range(0, 2097152)) - 1048576;
      if (i % 3 != 0) begin
        a1 = a0 + longint'($urandom_range(0, 262144)) - 131072;
        b1 = b0 + longint'($urandom_range(0, 262144)) - 131072;
      end else begin
        a1 = longint'($urandom_range(0, 2097152)) - 1048576;
        b1 = longint'($urandom_range(0, 2097152)) - 1048576;
      end
      c0 = longint'($urandom_range(0, 150000)); c1 = longint'($urandom_range(0, 150000));
      model(a0, b0, a1, b1, c0, c1, 0, eh, e0, f0, e1, f1);
      model(a0, b0, a1, b1, c0, c1, 1, eh1, g0, h0, g1, h1);
      if (eh) nhit++;
      start_pair(a0, b0, a1, b1, c0, c1, w);
      wait_done(lat);
      checks++; if (lat != (eh ? LAT_HIT : LAT_MISS) || hit !== eh)
        begin errors++; $display("FAIL rnd%0d_ctl: lat=%0d hit=%0b want %0d %0b", i, lat, hit, eh ? LAT_HIT : LAT_MISS, eh); end
      checks++; if (nx0 !== W'(e0) || ny0 !== W'(f0) || nx1 !== W'(e1) || ny1 !== W'(f1))
        begin errors++; $display("FAIL rnd%0d_m0: got %0d %0d %0d %0d want %0d %0d %0d %0d", i, nx0, ny0, nx1, ny1, e0, f0, e1, f1); end
      checks++; if (bx0 !== W'(g0) || by0 !== W'(h0) || bx1 !== W'(g1) || by1 !== W'(h1) || hit_b !== eh1)
        begin errors++; $display("FAIL rnd%0d_m1: got %0d %0d %0d %0d want %0d %0d %0d %0d", i, bx0, by0, bx1, by1, g0, h0, g1, h1); end
      xfer();
    end
    checks++; if (nhit == 0) begin errors++; $display("FAIL rnd_coverage: hits=%0d want >0", nhit); end
  endtask

  initial begin
    test_reset();
    test_nohit();
    test_hit_axis("axis");
    test_diag();
    test_coincident();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
